rca_wb_control: RTL and testbench
=================================

Name: rca_wb_control

Overview:
- Writeback-side controller for the reconfigurable accelerator (RCA) unit.
- Takes results from the output FIFO of the currently running RCA and pairs each result with the head of the in-order ID tracking FIFO.
- Presents each result to the core writeback interface with a done/ack handshake. On ack it pops the ID FIFO via wb_committing, and forwards feedback-instruction results back to the grid.

Parameters:
XLEN, 32, result data width
NUM_RCAS, 4, number of accelerators; rca select width is $clog2(NUM_RCAS)
ID_WIDTH, 3, width of instruction ID (id_t)
COUNT_WIDTH, 16, width of commit performance counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
currently_running_rca  in  $clog2(NUM_RCAS)  RCA whose output FIFO is serviced
clear_fifos  in  1  accelerator switch in progress; blocks capture this cycle
fifo_populated  in  1  ID tracking FIFO non-empty
wb_id  in  ID_WIDTH  head of ID tracking FIFO
wb_fb_instr  in  1  head ID is a feedback-use instruction
result_valid  in  NUM_RCAS  per-RCA output FIFO non-empty
result_data  in  NUM_RCAS x XLEN  per-RCA output FIFO head data
result_pop  out  NUM_RCAS  one-hot pop to per-RCA output FIFO
wb_committing  out  1  pop ID tracking FIFO
wb_done  out  1  result available to writeback
wb_rd  out  XLEN  writeback data
wb_id_out  out  ID_WIDTH  ID of result being written back
wb_ack  in  1  writeback accepted this cycle
fb_valid  out  1  one-cycle pulse: feedback result to grid
fb_data  out  XLEN  feedback result data
orphan_result  out  1  sticky error: result seen with no tracked ID
commit_count  out  COUNT_WIDTH  number of committed results, wraps

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - wb_done, fb_valid, orphan_result, commit_count, pending registers = 0.
  - Combinational outputs (result_pop, wb_committing) = 0 while in reset.
- States: IDLE, WB_PENDING.
- Capture condition in IDLE: cap = fifo_populated && result_valid[currently_running_rca] && !clear_fifos.
- IDLE, cap true:
  - result_pop[currently_running_rca] = 1 combinationally, exactly one cycle.
  - Register result_data[sel], wb_id and wb_fb_instr into pending registers.
  - Next state = WB_PENDING.
- IDLE, cap false: result_pop = 0; stay in IDLE.
- WB_PENDING:
  - wb_done = 1; wb_rd and wb_id_out driven from pending registers, stable until ack.
  - result_pop = 0.
  - On wb_ack: wb_committing = 1 combinationally in the same cycle; commit_count increments (modulo 2^COUNT_WIDTH); next state = IDLE.
  - If pending_fb is set, fb_valid = 1 on the cycle after ack (registered) and fb_data = pending data.
- wb_done is a registered output: high exactly while in WB_PENDING, low the cycle after ack.
- Minimum latency:
  - result_valid to wb_done: 1 cycle.
  - Ack to next capture: 1 cycle (next capture possible the cycle after ack, in IDLE).
  - Sustained throughput: 1 result per 2 cycles.
- Simultaneous events:
  - clear_fifos in IDLE suppresses capture and pop that cycle.
  - clear_fifos in WB_PENDING has no effect; the pending result completes.
- Orphan: in IDLE, result_valid[currently_running_rca] && !fifo_populated && !clear_fifos sets orphan_result (sticky until reset). No pop occurs.
- Selection:
  - result_valid and result_data of non-selected RCAs are ignored.
  - currently_running_rca changes while in WB_PENDING do not affect the pending result.
- wb_ack while in IDLE is ignored (no commit, no count).
- Mid-operation reset drops any pending result; no pop or commit is emitted on reset release.

Test Plan:
- Single result: sel=2, fifo_populated=1, wb_id=5, result_valid[2]=1, data=0xDEADBEEF; ack 3 cycles later.
  -> result_pop=4'b0100 for one cycle, wb_done next cycle with wb_rd=0xDEADBEEF, wb_id_out=5.
  -> wb_committing on the ack cycle, commit_count=1, wb_done low after.
- Back-to-back: 4 results queued, ack tied high.
  -> 4 pops, 4 commits in 8 cycles, commit_count=4, IDs in FIFO order.
- Feedback: wb_fb_instr=1, data=0x12.
  -> fb_valid pulse one cycle after ack, fb_data=0x12; with wb_fb_instr=0 fb_valid stays 0.
- Clear/selection: clear_fifos=1 with result_valid[sel]=1 -> no pop; result_valid on a non-selected RCA only -> no pop, wb_done stays 0.
- Orphan: fifo_populated=0, result_valid[sel]=1 -> orphan_result=1 and held, result_pop=0.
- Reset and wrap:
  - Assert rst low in WB_PENDING -> wb_done=0 immediately, no commit after release.
  - Preload commit_count to 0xFFFF, one commit -> 0x0000.

Source files
------------

// File: rtl/rca_wb_control_if.sv
// Core writeback handshake between the RCA writeback controller and the core.
// The controller presents a result with wb_done. The core accepts it with wb_ack.
interface rca_wb_control_if #(
  parameter int XLEN     = 32,
  parameter int ID_WIDTH = 3
);
  logic                wb_done;
  logic [XLEN-1:0]     wb_rd;
  logic [ID_WIDTH-1:0] wb_id_out;
  logic                wb_ack;
  logic                wb_committing;

  modport master (output wb_done, wb_rd, wb_id_out, wb_committing, input wb_ack);
  modport slave  (input wb_done, wb_rd, wb_id_out, wb_committing, output wb_ack);
endinterface

// File: rtl/rca_wb_control.sv
// RCA writeback controller: pairs each result from the running RCA's output FIFO with
// the head of the in-order ID FIFO, hands it to writeback, and forwards feedback results.
module rca_wb_control #(
  parameter int  XLEN        = 32,
  parameter int  NUM_RCAS    = 4,
  parameter int  ID_WIDTH    = 3,
  parameter int  COUNT_WIDTH = 16,
  localparam int SEL_WIDTH   = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [SEL_WIDTH-1:0]           currently_running_rca,
  input  logic                           clear_fifos,
  input  logic                           fifo_populated,
  input  logic [ID_WIDTH-1:0]            wb_id,
  input  logic                           wb_fb_instr,
  input  logic [NUM_RCAS-1:0]            result_valid,
  input  logic [NUM_RCAS-1:0][XLEN-1:0]  result_data,
  output logic [NUM_RCAS-1:0]            result_pop,
  rca_wb_control_if.master               wb,
  output logic                           fb_valid,
  output logic [XLEN-1:0]                fb_data,
  output logic                           orphan_result,
  output logic [COUNT_WIDTH-1:0]         commit_count
);

  typedef enum logic {IDLE, WB_PENDING} state_t;

  state_t              state_q, state_d;
  logic                capture, orphan_seen;
  logic                sel_valid;
  logic [XLEN-1:0]     sel_data;
  logic [XLEN-1:0]     pending_data;
  logic [ID_WIDTH-1:0] pending_id;
  logic                pending_fb;

  assign sel_valid = result_valid[currently_running_rca];
  assign sel_data  = result_data[currently_running_rca];

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d          = state_q;
    capture          = 1'b0;
    orphan_seen      = 1'b0;
    result_pop       = '0;
    wb.wb_committing = 1'b0;
    case (state_q)
      IDLE: begin
        // Gating with rst keeps pop and commit quiet while reset is held.
        if (rst && sel_valid && !clear_fifos) begin
          if (fifo_populated) begin
            capture                           = 1'b1;
            result_pop[currently_running_rca] = 1'b1;
            state_d                           = WB_PENDING;
          end else begin
            orphan_seen = 1'b1;
          end
        end
      end
      WB_PENDING: begin
        if (rst && wb.wb_ack) begin
          wb.wb_committing = 1'b1;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      // NOTE: the pending result registers are a single entry, so they are reset as well; a mid-operation reset drops the result.
      pending_data  <= '0;
      pending_id    <= '0;
      pending_fb    <= 1'b0;
      fb_valid      <= 1'b0;
      fb_data       <= '0;
      orphan_result <= 1'b0;
      commit_count  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        pending_data <= sel_data;
        pending_id   <= wb_id;
        pending_fb   <= wb_fb_instr;
      end
      fb_valid <= wb.wb_committing && pending_fb;
      if (wb.wb_committing && pending_fb) fb_data <= pending_data;
      if (orphan_seen) orphan_result <= 1'b1;
      if (wb.wb_committing) commit_count <= commit_count + COUNT_WIDTH'(1);
    end
  end

  // wb_done comes straight from the state register, so it is glitch-free.
  assign wb.wb_done   = (state_q == WB_PENDING);
  assign wb.wb_rd     = pending_data;
  assign wb.wb_id_out = pending_id;

endmodule

// File: tb/tb_rca_wb_control.sv
// Directed bench for rca_wb_control. A second instance with a 4-bit commit counter
// runs on the same stimulus so that counter wrap is reached in a few cycles.
module tb_rca_wb_control;
  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        sel;
  logic              clear, fpop, fb, ack;
  logic [2:0]        wid;
  logic [3:0]        rv;
  logic [3:0][31:0]  rd;
  logic [3:0]        pop, pop_s;
  logic              fb_valid, fbv_s, orphan, orph_s;
  logic [31:0]       fb_data, fbd_s;
  logic [15:0]       count;
  logic [3:0]        count_s;
  int                errors = 0;
  int                checks = 0;
  int                exp_count = 0;

  always #5 clk = ~clk;

  rca_wb_control_if #(.XLEN(32), .ID_WIDTH(3)) wif ();
  rca_wb_control_if #(.XLEN(32), .ID_WIDTH(3)) wif_s ();
  assign wif.wb_ack   = ack;
  assign wif_s.wb_ack = ack;

  rca_wb_control #(.XLEN(32), .NUM_RCAS(4), .ID_WIDTH(3), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .currently_running_rca(sel), .clear_fifos(clear),
    .fifo_populated(fpop), .wb_id(wid), .wb_fb_instr(fb), .result_valid(rv),
    .result_data(rd), .result_pop(pop), .wb(wif.master), .fb_valid(fb_valid),
    .fb_data(fb_data), .orphan_result(orphan), .commit_count(count));

  rca_wb_control #(.XLEN(32), .NUM_RCAS(4), .ID_WIDTH(3), .COUNT_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst), .currently_running_rca(sel), .clear_fifos(clear),
    .fifo_populated(fpop), .wb_id(wid), .wb_fb_instr(fb), .result_valid(rv),
    .result_data(rd), .result_pop(pop_s), .wb(wif_s.master), .fb_valid(fbv_s),
    .fb_data(fbd_s), .orphan_result(orph_s), .commit_count(count_s));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 1'b0; fpop = 1'b0; rv = '0; fb = 1'b0; ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle_inputs(); sel = 2'd2; wid = 3'd5; rd = '0;
    fpop = 1'b1; rv = 4'b0100;
    #1;
    checks++; if (pop !== 4'b0000) begin errors++; $display("FAIL reset_pop: got %b expected 0000", pop); end
    checks++; if (wif.wb_committing !== 1'b0) begin errors++; $display("FAIL reset_commit: got %b expected 0", wif.wb_committing); end
    checks++; if (wif.wb_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", wif.wb_done); end
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (fb_valid !== 1'b0) begin errors++; $display("FAIL reset_fb_valid: got %b expected 0", fb_valid); end
    checks++; if (orphan !== 1'b0) begin errors++; $display("FAIL reset_orphan: got %b expected 0", orphan); end
    idle_inputs();
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_wrap();
    sel = 2'd0; fpop = 1'b1; rv = 4'b0001; rd[0] = 32'h0000_0077; wid = 3'd1; ack = 1'b1;
    for (int i = 0; i < 30; i++) step();
    checks++; if (count_s !== 4'hF) begin errors++; $display("FAIL wrap_pre_small: got %0d expected 15", count_s); end
    checks++; if (count !== 16'd15) begin errors++; $display("FAIL wrap_pre_wide: got %0d expected 15", count); end
    step(); step();
    idle_inputs();
    exp_count = 16;
    checks++; if (count_s !== 4'h0) begin errors++; $display("FAIL wrap_small: got %0d expected 0", count_s); end
    checks++; if (count !== 16'd16) begin errors++; $display("FAIL wrap_wide: got %0d expected 16", count); end
    step();
  endtask

  task automatic test_single();
    sel = 2'd2; fpop = 1'b1; wid = 3'd5; rv = 4'b0100;
    rd = {32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222, 32'h3333_3333};
    #1;
    checks++; if (pop !== 4'b0100) begin errors++; $display("FAIL single_pop: got %b expected 0100", pop); end
    checks++; if (wif.wb_done !== 1'b0) begin errors++; $display("FAIL single_done_early: got %b expected 0", wif.wb_done); end
    step();
    rv = '0; fpop = 1'b0;
    #1;
    checks++; if (pop !== 4'b0000) begin errors++; $display("FAIL single_pop_once: got %b expected 0000", pop); end
    checks++; if (wif.wb_done !== 1'b1) begin errors++; $display("FAIL single_done: got %b expected 1", wif.wb_done); end
    checks++; if (wif.wb_rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rd: got %h expected deadbeef", wif.wb_rd); end
    checks++; if (wif.wb_id_out !== 3'd5) begin errors++; $display("FAIL single_id: got %0d expected 5", wif.wb_id_out); end
    step(); step();
    checks++; if (wif.wb_done !== 1'b1 || wif.wb_rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_hold: got done=%b rd=%h expected 1/deadbeef", wif.wb_done, wif.wb_rd); end
    ack = 1'b1;
    #1;
    checks++; if (wif.wb_committing !== 1'b1) begin errors++; $display("FAIL single_commit: got %b expected 1", wif.wb_committing); end
    step();
    ack = 1'b0; exp_count++;
    #1;
    checks++; if (wif.wb_done !== 1'b0) begin errors++; $display("FAIL single_done_after: got %b expected 0", wif.wb_done); end
    checks++; if (count !== 16'(exp_count)) begin errors++; $display("FAIL single_count: got %0d expected %0d", count, exp_count); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ids [4];
    logic [31:0] dat [4];
    int          k = 0;
    logic        was_pop;
    ids[0] = 3'd3; ids[1] = 3'd6; ids[2] = 3'd1; ids[3] = 3'd7;
    dat[0] = 32'hA0A0_0000; dat[1] = 32'hB1B1_1111; dat[2] = 32'hC2C2_2222; dat[3] = 32'hD3D3_3333;
    sel = 2'd1; ack = 1'b1; rd[0] = 32'hBAD0_0000; rd[3] = 32'hBAD3_3333;
    for (int i = 0; i < 8; i++) begin
      fpop  = (k < 4);
      wid   = (k < 4) ? ids[k] : 3'd0;
      rd[1] = (k < 4) ? dat[k] : 32'd0;
      rv    = {1'b1, 1'b0, (k < 4), 1'b1};
      #1;
      checks++; if (pop !== ((i % 2 == 0) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL b2b_pop[%0d]: got %b", i, pop); end
      checks++; if (wif.wb_committing !== (i % 2 == 1)) begin errors++; $display("FAIL b2b_commit[%0d]: got %b expected %b", i, wif.wb_committing, (i % 2 == 1)); end
      if (i % 2 == 1) begin
        checks++; if (wif.wb_id_out !== ids[i/2]) begin errors++; $display("FAIL b2b_id[%0d]: got %0d expected %0d", i, wif.wb_id_out, ids[i/2]); end
        checks++; if (wif.wb_rd !== dat[i/2]) begin errors++; $display("FAIL b2b_rd[%0d]: got %h expected %h", i, wif.wb_rd, dat[i/2]); end
      end
      was_pop = pop[1];
      @(posedge clk);
      #1;
      if (was_pop) k++;
    end
    idle_inputs();
    exp_count += 4;
    checks++; if (count !== 16'(exp_count)) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", count, exp_count); end
  endtask

  task automatic test_feedback();
    for (int t = 0; t < 2; t++) begin
      sel = 2'd0; fb = (t == 0); fpop = 1'b1; wid = 3'd2; rv = 4'b0001; rd[0] = 32'h0000_0012;
      step();
      rv = '0; fpop = 1'b0; fb = 1'b0; rd[0] = 32'h0; ack = 1'b1;
      #1;
      checks++; if (wif.wb_committing !== 1'b1) begin errors++; $display("FAIL fb_commit[%0d]: got %b expected 1", t, wif.wb_committing); end
      checks++; if (fb_valid !== 1'b0) begin errors++; $display("FAIL fb_early[%0d]: got %b expected 0", t, fb_valid); end
      step();
      ack = 1'b0; exp_count++;
      checks++; if (fb_valid !== (t == 0)) begin errors++; $display("FAIL fb_valid[%0d]: got %b expected %b", t, fb_valid, (t == 0)); end
      if (t == 0) begin
        checks++; if (fb_data !== 32'h0000_0012) begin errors++; $display("FAIL fb_data: got %h expected 00000012", fb_data); end
      end
      step();
      checks++; if (fb_valid !== 1'b0) begin errors++; $display("FAIL fb_pulse[%0d]: got %b expected 0", t, fb_valid); end
    end
  endtask

  task automatic test_clear_select();
    sel = 2'd3; fpop = 1'b1; wid = 3'd4; rv = 4'b1000; rd[3] = 32'h0000_0055; clear = 1'b1;
    #1;
    checks++; if (pop !== 4'b0000) begin errors++; $display("FAIL clear_pop: got %b expected 0000", pop); end
    step();
    checks++; if (wif.wb_done !== 1'b0) begin errors++; $display("FAIL clear_done: got %b expected 0", wif.wb_done); end
    clear = 1'b0; sel = 2'd0; rv = 4'b1110;
    #1;
    checks++; if (pop !== 4'b0000) begin errors++; $display("FAIL unsel_pop: got %b expected 0000", pop); end
    step();
    checks++; if (wif.wb_done !== 1'b0 || orphan !== 1'b0) begin errors++; $display("FAIL unsel_state: got done=%b orphan=%b expected 0/0", wif.wb_done, orphan); end
    sel = 2'd3; rv = 4'b1000;
    step();
    rv = '0; fpop = 1'b0; clear = 1'b1; sel = 2'd1; rd[3] = 32'h0;
    step();
    checks++; if (wif.wb_done !== 1'b1 || wif.wb_rd !== 32'h55) begin errors++; $display("FAIL clear_pending: got done=%b rd=%h expected 1/00000055", wif.wb_done, wif.wb_rd); end
    ack = 1'b1;
    #1;
    checks++; if (wif.wb_committing !== 1'b1) begin errors++; $display("FAIL clear_pending_commit: got %b expected 1", wif.wb_committing); end
    step();
    idle_inputs(); exp_count++;
    checks++; if (count !== 16'(exp_count)) begin errors++; $display("FAIL clear_count: got %0d expected %0d", count, exp_count); end
  endtask

  task automatic test_orphan();
    sel = 2'd1; fpop = 1'b0; rv = 4'b0010;
    #1;
    checks++; if (pop !== 4'b0000) begin errors++; $display("FAIL orphan_pop: got %b expected 0000", pop); end
    step();
    rv = '0;
    checks++; if (orphan !== 1'b1) begin errors++; $display("FAIL orphan_set: got %b expected 1", orphan); end
    step(); step();
    checks++; if (orphan !== 1'b1 || wif.wb_done !== 1'b0) begin errors++; $display("FAIL orphan_hold: got orphan=%b done=%b expected 1/0", orphan, wif.wb_done); end
    checks++; if (count !== 16'(exp_count)) begin errors++; $display("FAIL orphan_count: got %0d expected %0d", count, exp_count); end
  endtask

  task automatic test_reset_mid();
    sel = 2'd2; fpop = 1'b1; wid = 3'd6; rv = 4'b0100; rd[2] = 32'hCAFE_0001;
    step();
    idle_inputs();
    #1;
    checks++; if (wif.wb_done !== 1'b1) begin errors++; $display("FAIL midrst_pending: got %b expected 1", wif.wb_done); end
    rst = 1'b0;
    #1;
    checks++; if (wif.wb_done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", wif.wb_done); end
    checks++; if (count !== 16'd0 || orphan !== 1'b0) begin errors++; $display("FAIL midrst_regs: got count=%0d orphan=%b expected 0/0", count, orphan); end
    ack = 1'b1;
    step(); step();
    rst = 1'b1;
    #1;
    checks++; if (wif.wb_committing !== 1'b0) begin errors++; $display("FAIL midrst_release_commit: got %b expected 0", wif.wb_committing); end
    step();
    checks++; if (count !== 16'd0 || wif.wb_done !== 1'b0 || pop !== 4'b0000) begin errors++; $display("FAIL midrst_after: got count=%0d done=%b pop=%b expected 0/0/0000", count, wif.wb_done, pop); end
    ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_single();
    test_back_to_back();
    test_feedback();
    test_clear_select();
    test_orphan();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
